// File: rtl/mesh_route_unit.sv
// Per-input-port route computation for the MESH router: latches a one-hot output-port
// request on head acceptance and holds it until the tail flit is consumed (wormhole).
module mesh_route_unit #(
  parameter int X_NODES  = 4,
  parameter int Y_NODES  = 4,
  parameter int X_LOC    = 0,
  parameter int Y_LOC    = 0,
  parameter int TORUS    = 0,
  parameter int MODE     = 0,
  parameter int CREDIT_W = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [$clog2(X_NODES)-1:0]  i_x_dest,
  input  logic [$clog2(Y_NODES)-1:0]  i_y_dest,
  input  logic                        i_val,
  input  logic                        i_head,
  input  logic                        i_tail,
  input  logic                        i_grant,
  input  logic [5*CREDIT_W-1:0]       i_credit,
  output logic [0:4]                  o_output_req,
  output logic                        o_val,
  output logic                        o_err
);

  localparam logic WRAP     = (TORUS != 0);
  localparam logic ADAPTIVE = (MODE == 2) && (TORUS == 0);
  localparam logic Y_FIRST  = (MODE == 1);

  localparam logic [0:4] PORT_C = 5'b10000;
  localparam logic [0:4] PORT_N = 5'b01000;
  localparam logic [0:4] PORT_E = 5'b00100;
  localparam logic [0:4] PORT_S = 5'b00010;
  localparam logic [0:4] PORT_W = 5'b00001;

  typedef enum logic [1:0] {D_NONE = 2'd0, D_POS = 2'd1, D_NEG = 2'd2} dir_e;
  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;

  // Productive direction along one axis; on a torus the half-way tie goes positive.
  function automatic dir_e axis_dir(input int dest, input int loc, input int nodes,
                                    input logic wrap);
    int d;
    if (wrap) begin
      d = dest - loc;
      if (d < 0) d = d + nodes;
      if (d == 0) return D_NONE;
      return (d <= nodes / 2) ? D_POS : D_NEG;
    end
    if (dest > loc) return D_POS;
    if (dest < loc) return D_NEG;
    return D_NONE;
  endfunction

  function automatic logic [0:4] pick_port(input dir_e xd, input dir_e yd,
                                           input logic [CREDIT_W-1:0] cx,
                                           input logic [CREDIT_W-1:0] cy);
    logic [0:4] xp;
    logic [0:4] yp;
    xp = (xd == D_POS) ? PORT_E : PORT_W;
    yp = (yd == D_POS) ? PORT_N : PORT_S;
    if (xd == D_NONE && yd == D_NONE) return PORT_C;
    if (ADAPTIVE) begin
      // West-first: any westward hop is taken first, so only e vs n/s is ever adaptive.
      if (xd == D_NEG)  return PORT_W;
      if (xd == D_NONE) return yp;
      if (yd == D_NONE) return xp;
      return (cy > cx) ? yp : xp;
    end
    if (Y_FIRST) return (yd != D_NONE) ? yp : xp;
    return (xd != D_NONE) ? xp : yp;
  endfunction

  state_e      state_q;
  logic [0:4]  req_q;
  logic        val_q;
  logic        err_q;

  dir_e                 x_dir;
  dir_e                 y_dir;
  logic                 dest_bad;
  logic [CREDIT_W-1:0]  cred_n;
  logic [CREDIT_W-1:0]  cred_e;
  logic [CREDIT_W-1:0]  cred_s;
  logic [CREDIT_W-1:0]  cred_y;
  logic [0:4]           route_d;

  always_comb begin
    cred_n   = i_credit[4*CREDIT_W-1 -: CREDIT_W];
    cred_e   = i_credit[3*CREDIT_W-1 -: CREDIT_W];
    cred_s   = i_credit[2*CREDIT_W-1 -: CREDIT_W];
    x_dir    = axis_dir(int'(i_x_dest), X_LOC, X_NODES, WRAP);
    y_dir    = axis_dir(int'(i_y_dest), Y_LOC, Y_NODES, WRAP);
    cred_y   = (y_dir == D_POS) ? cred_n : cred_s;
    dest_bad = (int'(i_x_dest) >= X_NODES) || (int'(i_y_dest) >= Y_NODES);
    route_d  = dest_bad ? PORT_C : pick_port(x_dir, y_dir, cred_e, cred_y);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_val) begin
            if (i_head) begin
              state_q <= S_ACTIVE;
              req_q   <= route_d;
              val_q   <= 1'b1;
              err_q   <= dest_bad;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (i_val) begin
            if (i_grant) begin
              // A granted head here is still consumed; it only raises the error flag.
              if (i_head) err_q <= 1'b1;
              if (i_tail) begin
                state_q <= S_IDLE;
                req_q   <= '0;
                val_q   <= 1'b0;
              end
            end else if (i_head) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= '0;
          val_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_output_req = req_q;
  assign o_val        = val_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_mesh_route_unit.sv
// Directed bench for mesh_route_unit: five instances (mesh XY/YX/west-first, torus, 3x3 mesh)
// share one stimulus bus; each scenario resets all of them and checks the relevant one.
module tb_mesh_route_unit;

  localparam logic [4:0] P_C = 5'b10000;
  localparam logic [4:0] P_N = 5'b01000;
  localparam logic [4:0] P_E = 5'b00100;
  localparam logic [4:0] P_S = 5'b00010;
  localparam logic [4:0] P_W = 5'b00001;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  x_dest = '0;
  logic [1:0]  y_dest = '0;
  logic        val = 1'b0;
  logic        head = 1'b0;
  logic        tail = 1'b0;
  logic        grant = 1'b0;
  logic [14:0] credit = '0;

  logic [0:4] req_a, req_b, req_c, req_d, req_e;
  logic       val_a, val_b, val_c, val_d, val_e;
  logic       err_a, err_b, err_c, err_d, err_e;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mesh_route_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1), .TORUS(0), .MODE(0), .CREDIT_W(3))
    u_xy (.clk(clk), .reset_n(reset_n), .i_x_dest(x_dest), .i_y_dest(y_dest), .i_val(val),
          .i_head(head), .i_tail(tail), .i_grant(grant), .i_credit(credit),
          .o_output_req(req_a), .o_val(val_a), .o_err(err_a));

  mesh_route_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(0), .Y_LOC(0), .TORUS(1), .MODE(0), .CREDIT_W(3))
    u_torus (.clk(clk), .reset_n(reset_n), .i_x_dest(x_dest), .i_y_dest(y_dest), .i_val(val),
             .i_head(head), .i_tail(tail), .i_grant(grant), .i_credit(credit),
             .o_output_req(req_b), .o_val(val_b), .o_err(err_b));

  mesh_route_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1), .TORUS(0), .MODE(2), .CREDIT_W(3))
    u_wf (.clk(clk), .reset_n(reset_n), .i_x_dest(x_dest), .i_y_dest(y_dest), .i_val(val),
          .i_head(head), .i_tail(tail), .i_grant(grant), .i_credit(credit),
          .o_output_req(req_c), .o_val(val_c), .o_err(err_c));

  mesh_route_unit #(.X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(1), .TORUS(0), .MODE(1), .CREDIT_W(3))
    u_yx (.clk(clk), .reset_n(reset_n), .i_x_dest(x_dest), .i_y_dest(y_dest), .i_val(val),
          .i_head(head), .i_tail(tail), .i_grant(grant), .i_credit(credit),
          .o_output_req(req_d), .o_val(val_d), .o_err(err_d));

  mesh_route_unit #(.X_NODES(3), .Y_NODES(3), .X_LOC(1), .Y_LOC(1), .TORUS(0), .MODE(0), .CREDIT_W(3))
    u_m3 (.clk(clk), .reset_n(reset_n), .i_x_dest(x_dest), .i_y_dest(y_dest), .i_val(val),
          .i_head(head), .i_tail(tail), .i_grant(grant), .i_credit(credit),
          .o_output_req(req_e), .o_val(val_e), .o_err(err_e));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h, input logic t, input logic g,
                       input logic [1:0] x, input logic [1:0] y);
    val = v; head = h; tail = t; grant = g; x_dest = x; y_dest = y;
  endtask

  function automatic logic [14:0] cred(input logic [2:0] c, input logic [2:0] n,
                                       input logic [2:0] e, input logic [2:0] s,
                                       input logic [2:0] w);
    return {c, n, e, s, w};
  endfunction

  task automatic do_reset();
    drive(0, 0, 0, 0, 2'd0, 2'd0);
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Present a head flit (not granted) for one cycle, then go quiet.
  task automatic send_head(input logic [1:0] x, input logic [1:0] y);
    drive(1, 1, 0, 0, x, y);
    step();
    drive(0, 0, 0, 0, 2'd0, 2'd0);
  endtask

  // Consume a tail flit, then go quiet.
  task automatic end_pkt();
    drive(1, 0, 1, 1, 2'd0, 2'd0);
    step();
    drive(0, 0, 0, 0, 2'd0, 2'd0);
  endtask

  initial begin
    // Reset state, observed before any clock edge.
    #1;
    check("rst_req_a", 32'(req_a), 32'(5'b00000));
    check("rst_val_a", 32'(val_a), 32'd0);
    check("rst_err_a", 32'(err_a), 32'd0);
    check("rst_val_b", 32'(val_b), 32'd0);

    // XY mesh, loc (1,1): dest (3,2) goes east and holds through body flits.
    do_reset();
    send_head(2'd3, 2'd2);
    check("xy_head_req", 32'(req_a), 32'(P_E));
    check("xy_head_val", 32'(val_a), 32'd1);
    check("xy_head_err", 32'(err_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 2'd0, 2'd0);
      credit = cred(3'd7, 3'd7, 3'd0, 3'd7, 3'd7);
      step();
      check($sformatf("xy_body%0d_req", i), 32'(req_a), 32'(P_E));
      check($sformatf("xy_body%0d_val", i), 32'(val_a), 32'd1);
    end
    end_pkt();
    check("xy_tail_val", 32'(val_a), 32'd0);
    check("xy_tail_req", 32'(req_a), 32'(5'b00000));

    // Torus 4x4 at (0,0): wrap west, half-way tie east, wrap south, local.
    do_reset();
    send_head(2'd3, 2'd0);
    check("tor_w", 32'(req_b), 32'(P_W));
    end_pkt();
    check("tor_w_done", 32'(val_b), 32'd0);
    send_head(2'd2, 2'd0);
    check("tor_tie_e", 32'(req_b), 32'(P_E));
    end_pkt();
    send_head(2'd0, 2'd3);
    check("tor_s", 32'(req_b), 32'(P_S));
    end_pkt();
    send_head(2'd0, 2'd0);
    check("tor_c", 32'(req_b), 32'(P_C));
    check("tor_c_val", 32'(val_b), 32'd1);
    end_pkt();

    // West-first adaptive, loc (1,1), dest (3,3): e vs n decided on credits.
    do_reset();
    credit = cred(3'd0, 3'd2, 3'd5, 3'd0, 3'd0);
    send_head(2'd3, 2'd3);
    check("wf_e_more", 32'(req_c), 32'(P_E));
    end_pkt();
    credit = cred(3'd0, 3'd4, 3'd4, 3'd0, 3'd0);
    send_head(2'd3, 2'd3);
    check("wf_tie_e", 32'(req_c), 32'(P_E));
    end_pkt();
    credit = cred(3'd0, 3'd3, 3'd0, 3'd0, 3'd0);
    send_head(2'd3, 2'd3);
    check("wf_e_zero_n", 32'(req_c), 32'(P_N));
    credit = cred(3'd0, 3'd0, 3'd7, 3'd0, 3'd0);
    step();
    check("wf_held", 32'(req_c), 32'(P_N));
    end_pkt();
    credit = cred(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    send_head(2'd3, 2'd3);
    check("wf_both_zero_e", 32'(req_c), 32'(P_E));
    end_pkt();
    credit = cred(3'd7, 3'd7, 3'd7, 3'd7, 3'd0);
    send_head(2'd0, 2'd3);
    check("wf_west", 32'(req_c), 32'(P_W));
    end_pkt();

    // YX, loc (1,1): dest (3,2) goes north; single-flit packet then back-to-back head.
    do_reset();
    drive(1, 1, 1, 0, 2'd3, 2'd2);
    step();
    check("yx_n", 32'(req_d), 32'(P_N));
    check("yx_n_val", 32'(val_d), 32'd1);
    drive(1, 1, 1, 1, 2'd3, 2'd2);
    step();
    check("yx_single_done", 32'(val_d), 32'd0);
    drive(1, 1, 0, 0, 2'd0, 2'd1);
    step();
    drive(0, 0, 0, 0, 2'd0, 2'd0);
    check("yx_b2b_val", 32'(val_d), 32'd1);
    check("yx_b2b_w", 32'(req_d), 32'(P_W));
    check("yx_b2b_err", 32'(err_d), 32'd0);

    // Protocol errors on the XY instance.
    do_reset();
    drive(1, 0, 0, 0, 2'd0, 2'd0);
    step();
    check("body_idle_err", 32'(err_a), 32'd1);
    check("body_idle_val", 32'(val_a), 32'd0);
    drive(0, 0, 0, 0, 2'd0, 2'd0);
    step();
    check("err_pulse_end", 32'(err_a), 32'd0);
    send_head(2'd3, 2'd2);
    drive(1, 1, 0, 0, 2'd0, 2'd1);
    step();
    check("ungr_head_err", 32'(err_a), 32'd1);
    check("ungr_head_req", 32'(req_a), 32'(P_E));
    drive(1, 1, 0, 1, 2'd0, 2'd1);
    step();
    check("gr_head_err", 32'(err_a), 32'd1);
    check("gr_head_val", 32'(val_a), 32'd1);
    check("gr_head_req", 32'(req_a), 32'(P_E));
    end_pkt();

    // Out-of-range destination on the 3x3 mesh routes to c with an error.
    do_reset();
    send_head(2'd3, 2'd1);
    check("oor_x_req", 32'(req_e), 32'(P_C));
    check("oor_x_err", 32'(err_e), 32'd1);
    end_pkt();
    send_head(2'd1, 2'd3);
    check("oor_y_req", 32'(req_e), 32'(P_C));
    check("oor_y_err", 32'(err_e), 32'd1);
    end_pkt();
    send_head(2'd2, 2'd1);
    check("m3_e_req", 32'(req_e), 32'(P_E));
    check("m3_e_err", 32'(err_e), 32'd0);
    end_pkt();

    // Asynchronous reset mid-packet, between clock edges.
    do_reset();
    send_head(2'd3, 2'd2);
    drive(1, 1, 0, 0, 2'd0, 2'd1);
    step();
    check("pre_arst_err", 32'(err_a), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_val", 32'(val_a), 32'd0);
    check("arst_req", 32'(req_a), 32'(5'b00000));
    check("arst_err", 32'(err_a), 32'd0);
    drive(0, 0, 0, 0, 2'd0, 2'd0);
    step();
    reset_n = 1'b1;
    step();
    drive(1, 0, 0, 1, 2'd0, 2'd0);
    step();
    check("post_arst_body_err", 32'(err_a), 32'd1);
    check("post_arst_body_val", 32'(val_a), 32'd0);
    drive(0, 0, 0, 0, 2'd0, 2'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
